uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 19 +
 rtl/uart_transmitter.sv | 172 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: write handshake into the UART transmitter buffer.
// Signals: data (byte to send), send (write strobe), ready (write accepted).
interface uart_transmitter_if;
    logic [7:0] data;
    logic       send;
    logic       ready;

    modport master (
        output data,
        output send,
        input  ready
    );

    modport slave (
        input  data,
        input  send,
        output ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: one-bit-per-clk UART framer (start, 8 data LSB first, even
// parity, stop, IDLE_BITS idle-high cycles) fed from a write buffer.
// Ports: clk, reset (async active-high), bus (slave: data/send/ready),
//   tx (registered line, idle high), busy, level (buffer occupancy),
//   overflow (pulse while a write is being rejected).
// Macro UART_TX_FIFO_EN: FIFO_DEPTH-entry FIFO; otherwise a one-byte holding register.
module uart_transmitter #(
    parameter int IDLE_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_transmitter_if.slave   bus,
    output logic                tx,
    output logic                busy,
    output logic [4:0]          level,
    output logic                overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t      r_state;
    logic        r_tx;
    logic [2:0]  r_bit_idx;
    logic [3:0]  r_gap_cnt;
    logic [7:0]  r_shift;
    logic [4:0]  r_level;

    logic        w_full;
    logic        w_wr;
    logic        w_pop;
    logic        w_gap_last;
    logic [7:0]  w_head;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= bus.data;
    end

    assign w_head = r_mem[r_rptr];
`else
    // Holding register: depth is always one whatever FIFO_DEPTH says.
    localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;

    logic [7:0] r_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_hold <= '0;
        else if (w_wr)
            r_hold <= bus.data;
    end

    assign w_head = r_hold;
`endif

    // Everything below looks at pre-edge occupancy: a pop on the same
    // edge never frees room for a write to a full buffer.
    assign w_full     = (r_level == 5'(DEPTH));
    assign w_wr       = bus.send && !w_full;
    assign w_gap_last = (r_state == S_GAP) &&
                        (r_gap_cnt == 4'(IDLE_BITS - 1));
    assign w_pop      = (r_level != 5'd0) &&
                        ((r_state == S_IDLE) || w_gap_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_level <= '0;
        else if (w_wr && !w_pop)
            r_level <= r_level + 5'd1;
        else if (!w_wr && w_pop)
            r_level <= r_level - 5'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx      <= r_shift[0];
                    r_bit_idx <= 3'd0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit_idx == 3'd7) begin
                        r_tx      <= ^r_shift;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_PARITY;
                    end else begin
                        r_tx      <= r_shift[r_bit_idx + 3'd1];
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    r_tx    <= 1'b1;
                    r_state <= S_STOP;
                end
                S_STOP: begin
                    r_tx      <= 1'b1;
                    r_gap_cnt <= 4'd0;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (w_gap_last) begin
                        // Chain straight into the next start bit when data waits.
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = !w_full;
    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE) || (r_level != 5'd0);
    assign level     = r_level;
    assign overflow  = bus.send && w_full;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed stimulus against a queue-based line model,
// a negedge-sampling receiver and hand-computed frame literals.
module tb_uart_transmitter;

    localparam int IB = 1;
`ifdef UART_TX_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [4:0] level;

    uart_transmitter_if u_if();

    uart_transmitter #(
        .IDLE_BITS  (IB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (u_if),
        .tx       (tx),
        .busy     (busy),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: pending bytes plus the exact bit sequence still due on the line.
    logic [7:0] m_fifo[$];
    bit         m_line[$];

    initial forever begin
        bit         last;
        bit         acc;
        logic [7:0] b;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_fifo.delete();
            m_line.delete();
        end else begin
            last = (m_line.size() <= 1);
            acc  = u_if.send && (m_fifo.size() < D);
            if (m_line.size() > 0)
                m_line.delete(0);
            if (last && m_fifo.size() > 0) begin
                b = m_fifo.pop_front();
                m_line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    m_line.push_back(b[i]);
                m_line.push_back(^b);
                m_line.push_back(1'b1);
                for (int i = 0; i < IB; i++)
                    m_line.push_back(1'b1);
            end
            if (acc)
                m_fifo.push_back(u_if.data);
        end
    end

    initial forever begin
        int e_tx;
        int e_busy;
        @(negedge clk);
        if (cmp_on && !reset) begin
            e_tx   = (m_line.size() > 0) ? int'(m_line[0]) : 1;
            e_busy = (m_line.size() > 0 || m_fifo.size() > 0) ? 1 : 0;
            chk("m_tx", int'(tx), e_tx);
            chk("m_busy", int'(busy), e_busy);
            chk("m_level", int'(level), m_fifo.size());
            chk("m_ready", int'(u_if.ready), (m_fifo.size() < D) ? 1 : 0);
            chk("m_ovf", int'(overflow),
                (u_if.send && m_fifo.size() >= D) ? 1 : 0);
        end
    end

    // Downstream receiver sampling mid-bit on negedge.
    logic [7:0] rx_q[$];
    bit         rxe_q[$];

    initial forever begin
        bit         act;
        int         cnt;
        logic [9:0] sh;
        @(negedge clk or posedge reset);
        if (reset) begin
            act = 1'b0;
            cnt = 0;
        end else if (!act) begin
            if (tx == 1'b0) begin
                act = 1'b1;
                cnt = 0;
            end
        end else begin
            sh[cnt] = tx;
            cnt++;
            if (cnt == 10) begin
                act = 1'b0;
                rx_q.push_back(sh[7:0]);
                rxe_q.push_back(((^sh[7:0]) != sh[8]) || !sh[9]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        u_if.data = b;
        u_if.send = 1'b1;
        tick();
        u_if.send = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim, output int n);
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, lim);
        end
    endtask

    // exp holds the 11 frame bits, first bit on the line in exp[10].
    task automatic frame_lit(input string nm, input logic [10:0] exp);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk(nm, int'(tx), int'(exp[10-i]));
        end
    endtask

    task automatic chk_rx(input string nm, input int idx, input logic [7:0] b);
        if (idx < rx_q.size()) begin
            chk({nm, "_data"}, int'(rx_q[idx]), int'(b));
            chk({nm, "_err"}, int'(rxe_q[idx]), 0);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: byte %0d not received, required %0h", nm, idx, b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         n0;
        int         pk;
        logic [7:0] bl[$];
        int         lv[$];

        u_if.data = 8'h00;
        u_if.send = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(u_if.ready), 1);
        chk("rst_ovf", int'(overflow), 0);

        // Write pending as reset drops: taken on the first posedge after.
        u_if.data = 8'hA5;
        u_if.send = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        cmp_on = 1'b1;
        tick();
        u_if.send = 1'b0;
        chk("a5_level", int'(level), 1);
        chk("a5_busy", int'(busy), 1);
        frame_lit("a5_frame", 11'b01010010101);
        tick();
        chk("a5_gap", int'(tx), 1);
        tick();
        chk("a5_busy_k13", int'(busy), 0);

        put(8'h01);
        frame_lit("x01_frame", 11'b01000000011);
        tick();
        tick();
        chk("x01_busy_k13", int'(busy), 0);

`ifdef UART_TX_FIFO_EN
        n0 = rx_q.size();
        bl = '{8'h11, 8'h22, 8'h33, 8'h44};
        lv.delete();
        pk = 0;
        u_if.send = 1'b1;
        foreach (bl[i]) begin
            u_if.data = bl[i];
            chk("burst_ready", int'(u_if.ready), 1);
            tick();
            lv.push_back(int'(level));
            if (int'(level) > pk)
                pk = int'(level);
        end
        u_if.send = 1'b0;
        chk("burst_lv0", lv[0], 1);
        chk("burst_lv1", lv[1], 1);
        chk("burst_lv3", lv[3], 3);
        chk("burst_peak", pk, 3);
        wait_idle("burst_idle", 200, n);
        chk("burst_len", n, 46);
        foreach (bl[i])
            chk_rx("burst_rx", n0 + i, bl[i]);

        n0 = rx_q.size();
        bl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        lv.delete();
        u_if.send = 1'b1;
        foreach (bl[i]) begin
            u_if.data = bl[i];
            if (i == 5) begin
                chk("ovf_ready", int'(u_if.ready), 0);
                chk("ovf_pulse", int'(overflow), 1);
                chk("ovf_level", int'(level), 4);
            end
            tick();
            lv.push_back(int'(level));
        end
        u_if.send = 1'b0;
        chk("ovf_after", int'(overflow), 0);
        chk("ovf_lv4", lv[4], 4);
        chk("ovf_lv5", lv[5], 4);
        wait_idle("ovf_idle", 200, n);
        chk("ovf_len", n, 56);
        chk("ovf_rx_cnt", rx_q.size() - n0, 5);
        for (int i = 0; i < 5; i++)
            chk_rx("ovf_rx", n0 + i, bl[i]);
`else
        // Full holding register rejects even while it is being popped.
        n0 = rx_q.size();
        put(8'h3C);
        u_if.data = 8'hC3;
        u_if.send = 1'b1;
        chk("hold_ready", int'(u_if.ready), 0);
        chk("hold_ovf", int'(overflow), 1);
        tick();
        u_if.send = 1'b0;
        chk("hold_level", int'(level), 0);
        chk("hold_ovf_end", int'(overflow), 0);
        chk("hold_start", int'(tx), 0);
        wait_idle("hold_idle", 100, n);
        chk("hold_rx_cnt", rx_q.size() - n0, 1);
        chk_rx("hold_rx", n0, 8'h3C);
`endif

        // Reset during data bit 3 of 0xFF.
        n0 = rx_q.size();
        put(8'hFF);
        repeat (4) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_level", int'(level), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(u_if.ready), 1);
        chk("midrst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (14) tick();
        chk("midrst_quiet", int'(busy), 0);
        chk("midrst_norx", rx_q.size() - n0, 0);
        put(8'h5A);
        wait_idle("midrst_idle", 100, n);
        chk("midrst_rx_cnt", rx_q.size() - n0, 1);
        chk_rx("midrst_rx", n0, 8'h5A);

        n0 = rx_q.size();
        bl = '{8'h00, 8'h7F, 8'hFF, 8'hC3};
        foreach (bl[i]) begin
            put(bl[i]);
            wait_idle("loop_idle", 100, n);
        end
        chk("loop_rx_cnt", rx_q.size() - n0, 4);
        foreach (bl[i])
            chk_rx("loop_rx", n0 + i, bl[i]);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
